// File: rtl/clk_rst_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_pkg
// Shared definitions for the PLL reset sequencer:
//   - seq_state_e : sequencer FSM states
//   - RETRY_W     : width of the lock-timeout retry counter
//   - RETRY_MAX   : saturation value of the retry counter
//   - cnt_width() : shared cycle-counter width derived from the three timing
//                   parameters
//   - retry_sat_inc() : saturating increment of the retry counter
// -----------------------------------------------------------------------------
package clk_rst_pkg;

    localparam int unsigned RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_PLLRST    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    // One extra bit over $clog2 of the largest period so the terminal value of
    // every phase fits with headroom; parameters of 0 are not supported.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return $clog2(m) + 32'd1;
    endfunction

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        logic [RETRY_W-1:0] r;
        if (v == RETRY_MAX) begin
            r = v;
        end else begin
            r = v + {{(RETRY_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input level
//   q   : synchronised level (output of the second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-value logic for the two synchroniser stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops; the first stage may go metastable and is never used
    // directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Brings a PLL out of reset, waits for lock, holds lock for a stability window
// and only then releases the system reset. Loss of lock in RUN restarts the
// whole sequence; lock timeouts pulse the PLL reset again.
// Parameters (all must be >= 1):
//   PLL_RST_CYCLES : refclk cycles the PLL reset pulse is held
//   LOCK_TIMEOUT   : refclk cycles allowed for lock before retrying
//   STABLE_CYCLES  : consecutive synchronised-lock cycles before RUN
// Ports:
//   refclk    : free-running reference clock (only clock of this block)
//   rst       : asynchronous active-high reset
//   locked    : PLL lock, asynchronous to refclk
//   pll_rst   : active-high reset to the PLL
//   sys_rst   : active-high reset for PLL-clocked logic
//   ready     : high only in RUN
//   lock_lost : sticky, set when lock drops in RUN
//   retry_cnt : number of lock timeouts, saturating at 15
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1024
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 32'd1);
    // The locked_s sample that moves WAIT_LOCK into STABLE is the first of the
    // STABLE_CYCLES consecutive samples, so STABLE itself needs one fewer.
    localparam logic [CNT_W-1:0] STB_LAST = (STABLE_CYCLES >= 32'd2) ?
                                            CNT_W'(STABLE_CYCLES - 32'd2) : CNT_ZERO;

    logic               locked_s;

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               pll_rst_q;
    logic               pll_rst_d;
    logic               sys_rst_q;
    logic               sys_rst_d;
    logic               ready_q;
    logic               ready_d;
    logic               lock_lost_q;
    logic               lock_lost_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // Sequencer next-state, shared counter, sticky flag and retry counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = lock_lost_q;
        retry_d     = retry_q;
        case (state_q)
            ST_PLLRST: begin
                if (cnt_q >= PLL_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a timeout expiring on the same cycle.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = ST_PLLRST;
                    cnt_d   = CNT_ZERO;
                    retry_d = retry_sat_inc(retry_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // A dropout only restarts the lock wait; the PLL is not reset.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= STB_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d     = ST_PLLRST;
                    cnt_d       = CNT_ZERO;
                    lock_lost_d = 1'b1;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            default: begin
                // Unreachable encoding: recover through a full PLL reset.
                state_d = ST_PLLRST;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so outputs move with the state flop.
    always_comb begin
        pll_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        case (state_d)
            ST_PLLRST: begin
                pll_rst_d = 1'b1;
                sys_rst_d = 1'b1;
                ready_d   = 1'b0;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_rst_d = 1'b0;
                sys_rst_d = 1'b1;
                ready_d   = 1'b0;
            end
            ST_RUN: begin
                pll_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
                sys_rst_d = 1'b1;
                ready_d   = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; rst forces the safe reset values
    // without needing refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= CNT_ZERO;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= {RETRY_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            retry_q     <= retry_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule
